hsv_core_commit: RTL and testbench

- Final, in-order retirement stage of the hsv_core pipeline.
- Consumes commit_data from the alu, foo, mem, branch and ctrlstatus execution paths. Each path arrives through its skid buffer.
- Retires exactly one instruction per cycle, in token order, and performs the register-file write.
- Drives the ctrl_* event interface of ctrlstatus: commit, trap, mode return, wait-for-irq, flush begin. Publishes commit_token. Returns flush_ack_commit.

---
 rtl/hsv_core_commit.sv | 243 ++++++++++++++++++++++++
 tb/tb_hsv_core_commit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_commit.sv
`default_nettype none
// ============================================================================
// Module   : hsv_core_commit
// Purpose  : In-order retirement stage of the hsv_core pipeline. Selects the
//            execution unit whose instruction carries the current
//            commit_token, retires it (register-file write plus ctrl_* event
//            pulses) and runs the commit side of the pipeline flush
//            handshake.
// Ports    : clk_core / rst_core_n        clock, async active-low reset
//            valid_i / ready_o            per-unit commit handshake
//            in_*                         per-unit commit_data fields
//            rf_wr_*                      register-file write port
//            commit_token                 token of next instruction to retire
//            ctrl_*                       events towards ctrlstatus
//            ctrl_begin_irq               interrupt demand from ctrlstatus
//            flush_req / flush_ack_commit global flush handshake
// Revision : 1.0 - initial release
// ============================================================================
module hsv_core_commit #(
  parameter int NUM_UNITS = 5,
  parameter int TOKEN_W   = 2
) (
  input  logic                         clk_core,
  input  logic                         rst_core_n,
  input  logic [NUM_UNITS-1:0]         valid_i,
  output logic [NUM_UNITS-1:0]         ready_o,
  input  logic [NUM_UNITS*TOKEN_W-1:0] in_token,
  input  logic [NUM_UNITS*32-1:0]      in_pc,
  input  logic [NUM_UNITS*32-1:0]      in_next_pc,
  input  logic [NUM_UNITS*5-1:0]       in_rd,
  input  logic [NUM_UNITS*32-1:0]      in_rd_value,
  input  logic [NUM_UNITS-1:0]         in_writeback,
  input  logic [NUM_UNITS-1:0]         in_exception,
  input  logic [NUM_UNITS*5-1:0]       in_cause,
  input  logic [NUM_UNITS*32-1:0]      in_tval,
  input  logic [NUM_UNITS-1:0]         in_mode_return,
  input  logic [NUM_UNITS-1:0]         in_wait_irq,
  output logic                         rf_wr_en,
  output logic [4:0]                   rf_wr_addr,
  output logic [31:0]                  rf_wr_data,
  output logic [TOKEN_W-1:0]           commit_token,
  output logic                         ctrl_commit,
  output logic                         ctrl_flush_begin,
  output logic                         ctrl_trap,
  output logic [4:0]                   ctrl_trap_cause,
  output logic [31:0]                  ctrl_trap_value,
  output logic                         ctrl_mode_return,
  output logic                         ctrl_wait_irq,
  output logic [31:0]                  ctrl_next_pc,
  input  logic                         ctrl_begin_irq,
  input  logic                         flush_req,
  output logic                         flush_ack_commit
);

  localparam logic [1:0] c_st_run        = 2'd0;
  localparam logic [1:0] c_st_flush_wait = 2'd1;
  localparam logic [1:0] c_st_flush_ack  = 2'd2;

  logic [1:0]           r_state, w_state_next;
  logic [TOKEN_W-1:0]   r_token, w_token_next;
  logic                 r_rf_wr_en, w_rf_wr_en;
  logic [4:0]           r_rf_wr_addr, w_rf_wr_addr;
  logic [31:0]          r_rf_wr_data, w_rf_wr_data;
  logic                 r_commit, w_commit;
  logic                 r_flush_begin, w_flush_begin;
  logic                 r_trap, w_trap;
  logic [4:0]           r_trap_cause, w_trap_cause;
  logic [31:0]          r_trap_value, w_trap_value;
  logic                 r_mode_return, w_mode_return;
  logic                 r_wait_irq, w_wait_irq;
  logic [31:0]          r_next_pc, w_next_pc;
  logic                 r_flush_ack, w_flush_ack;

  // Selected-unit view of commit_data
  logic [NUM_UNITS-1:0] w_grant;
  logic                 w_has_cand;
  logic [31:0]          w_sel_pc, w_sel_next_pc, w_sel_rd_value, w_sel_tval;
  logic [4:0]           w_sel_rd, w_sel_cause;
  logic                 w_sel_wb, w_sel_exc, w_sel_mret, w_sel_wfi;
  logic                 w_retire, w_special;

  // Lowest-index unit holding the current token wins; others stay stalled.
  always_comb begin
    w_grant        = '0;
    w_has_cand     = 1'b0;
    w_sel_pc       = '0;
    w_sel_next_pc  = '0;
    w_sel_rd       = '0;
    w_sel_rd_value = '0;
    w_sel_wb       = 1'b0;
    w_sel_exc      = 1'b0;
    w_sel_cause    = '0;
    w_sel_tval     = '0;
    w_sel_mret     = 1'b0;
    w_sel_wfi      = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (!w_has_cand && valid_i[u] &&
          (in_token[u*TOKEN_W +: TOKEN_W] == r_token)) begin
        w_has_cand     = 1'b1;
        w_grant[u]     = 1'b1;
        w_sel_pc       = in_pc[u*32 +: 32];
        w_sel_next_pc  = in_next_pc[u*32 +: 32];
        w_sel_rd       = in_rd[u*5 +: 5];
        w_sel_rd_value = in_rd_value[u*32 +: 32];
        w_sel_wb       = in_writeback[u];
        w_sel_exc      = in_exception[u];
        w_sel_cause    = in_cause[u*5 +: 5];
        w_sel_tval     = in_tval[u*32 +: 32];
        w_sel_mret     = in_mode_return[u];
        w_sel_wfi      = in_wait_irq[u];
      end
    end
  end

  // An interrupt demand blocks the retire, so the candidate is not consumed.
  assign w_retire  = (r_state == c_st_run) && w_has_cand && !ctrl_begin_irq;
  assign w_special = w_sel_exc || w_sel_mret || w_sel_wfi;

  // Outside RUN every unit is drained: accepted and discarded.
  assign ready_o = (r_state != c_st_run) ? {NUM_UNITS{1'b1}}
                 : (w_retire ? w_grant : '0);

  // State and output registers
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_state       <= c_st_run;
      r_token       <= '0;
      r_rf_wr_en    <= 1'b0;
      r_rf_wr_addr  <= '0;
      r_rf_wr_data  <= '0;
      r_commit      <= 1'b0;
      r_flush_begin <= 1'b0;
      r_trap        <= 1'b0;
      r_trap_cause  <= '0;
      r_trap_value  <= '0;
      r_mode_return <= 1'b0;
      r_wait_irq    <= 1'b0;
      r_next_pc     <= '0;
      r_flush_ack   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_token       <= w_token_next;
      r_rf_wr_en    <= w_rf_wr_en;
      r_rf_wr_addr  <= w_rf_wr_addr;
      r_rf_wr_data  <= w_rf_wr_data;
      r_commit      <= w_commit;
      r_flush_begin <= w_flush_begin;
      r_trap        <= w_trap;
      r_trap_cause  <= w_trap_cause;
      r_trap_value  <= w_trap_value;
      r_mode_return <= w_mode_return;
      r_wait_irq    <= w_wait_irq;
      r_next_pc     <= w_next_pc;
      r_flush_ack   <= w_flush_ack;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_run: begin
        // A normal retire coinciding with flush_req still completes here;
        // the transition to FLUSH_WAIT happens on the same edge.
        if (ctrl_begin_irq || (w_retire && w_special) || flush_req)
          w_state_next = c_st_flush_wait;
      end
      c_st_flush_wait: begin
        if (flush_req)
          w_state_next = c_st_flush_ack;
      end
      c_st_flush_ack: begin
        if (!flush_req)
          w_state_next = c_st_run;
      end
      default: w_state_next = c_st_run;
    endcase
  end

  // Output logic (values registered on the next edge)
  always_comb begin
    w_token_next  = r_token;
    w_rf_wr_en    = 1'b0;
    w_rf_wr_addr  = r_rf_wr_addr;
    w_rf_wr_data  = r_rf_wr_data;
    w_commit      = 1'b0;
    w_flush_begin = 1'b0;
    w_trap        = 1'b0;
    w_trap_cause  = r_trap_cause;
    w_trap_value  = r_trap_value;
    w_mode_return = 1'b0;
    w_wait_irq    = 1'b0;
    w_next_pc     = r_next_pc;
    w_flush_ack   = (w_state_next == c_st_flush_ack);

    if (r_state == c_st_run) begin
      if (ctrl_begin_irq) begin
        w_flush_begin = 1'b1;
        if (w_has_cand)
          w_next_pc = w_sel_pc;
      end else if (w_retire) begin
        w_token_next = r_token + TOKEN_W'(1);
        if (w_sel_exc) begin
          // Exception outranks mret/wfi and suppresses the write.
          w_trap        = 1'b1;
          w_trap_cause  = w_sel_cause;
          w_trap_value  = w_sel_tval;
          w_next_pc     = w_sel_pc;
          w_flush_begin = 1'b1;
        end else begin
          w_commit      = 1'b1;
          w_next_pc     = w_sel_next_pc;
          w_rf_wr_en    = w_sel_wb && (w_sel_rd != 5'd0);
          w_rf_wr_addr  = w_sel_rd;
          w_rf_wr_data  = w_sel_rd_value;
          w_mode_return = w_sel_mret;
          w_wait_irq    = w_sel_wfi;
          w_flush_begin = w_sel_mret || w_sel_wfi;
        end
      end
    end

    // The token restarts from zero once the flush is acknowledged.
    if (w_state_next == c_st_flush_ack)
      w_token_next = '0;
  end

  assign rf_wr_en         = r_rf_wr_en;
  assign rf_wr_addr       = r_rf_wr_addr;
  assign rf_wr_data       = r_rf_wr_data;
  assign commit_token     = r_token;
  assign ctrl_commit      = r_commit;
  assign ctrl_flush_begin = r_flush_begin;
  assign ctrl_trap        = r_trap;
  assign ctrl_trap_cause  = r_trap_cause;
  assign ctrl_trap_value  = r_trap_value;
  assign ctrl_mode_return = r_mode_return;
  assign ctrl_wait_irq    = r_wait_irq;
  assign ctrl_next_pc     = r_next_pc;
  assign flush_ack_commit = r_flush_ack;

endmodule
`default_nettype wire

// File: tb/tb_hsv_core_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hsv_core_commit
// Purpose  : Directed self-checking bench for hsv_core_commit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hsv_core_commit;

  logic         clk_core = 1'b0;
  logic         rst_core_n = 1'b0;
  logic [4:0]   valid_i;
  logic [4:0]   ready_o;
  logic [9:0]   in_token;
  logic [159:0] in_pc, in_next_pc, in_rd_value, in_tval;
  logic [24:0]  in_rd, in_cause;
  logic [4:0]   in_writeback, in_exception, in_mode_return, in_wait_irq;
  logic         rf_wr_en;
  logic [4:0]   rf_wr_addr;
  logic [31:0]  rf_wr_data;
  logic [1:0]   commit_token;
  logic         ctrl_commit, ctrl_flush_begin, ctrl_trap;
  logic [4:0]   ctrl_trap_cause;
  logic [31:0]  ctrl_trap_value;
  logic         ctrl_mode_return, ctrl_wait_irq;
  logic [31:0]  ctrl_next_pc;
  logic         ctrl_begin_irq, flush_req, flush_ack_commit;

  int tests_run = 0;
  int tests_failed = 0;

  hsv_core_commit #(.NUM_UNITS(5), .TOKEN_W(2)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n),
    .valid_i(valid_i), .ready_o(ready_o), .in_token(in_token),
    .in_pc(in_pc), .in_next_pc(in_next_pc), .in_rd(in_rd),
    .in_rd_value(in_rd_value), .in_writeback(in_writeback),
    .in_exception(in_exception), .in_cause(in_cause), .in_tval(in_tval),
    .in_mode_return(in_mode_return), .in_wait_irq(in_wait_irq),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .commit_token(commit_token), .ctrl_commit(ctrl_commit),
    .ctrl_flush_begin(ctrl_flush_begin), .ctrl_trap(ctrl_trap),
    .ctrl_trap_cause(ctrl_trap_cause), .ctrl_trap_value(ctrl_trap_value),
    .ctrl_mode_return(ctrl_mode_return), .ctrl_wait_irq(ctrl_wait_irq),
    .ctrl_next_pc(ctrl_next_pc), .ctrl_begin_irq(ctrl_begin_irq),
    .flush_req(flush_req), .flush_ack_commit(flush_ack_commit)
  );

  always #5 clk_core = ~clk_core;

  task automatic clear_inputs;
    valid_i = '0; in_token = '0; in_pc = '0; in_next_pc = '0; in_rd = '0;
    in_rd_value = '0; in_writeback = '0; in_exception = '0; in_cause = '0;
    in_tval = '0; in_mode_return = '0; in_wait_irq = '0;
    ctrl_begin_irq = 1'b0; flush_req = 1'b0;
  endtask

  task automatic set_unit(input int u, input logic [1:0] tok,
                          input logic [31:0] pc, input logic [31:0] npc,
                          input logic [4:0] rd, input logic [31:0] val,
                          input logic wb, input logic exc,
                          input logic [4:0] cause, input logic [31:0] tval,
                          input logic mret, input logic wfi);
    valid_i[u] = 1'b1;
    in_token[u*2 +: 2] = tok;
    in_pc[u*32 +: 32] = pc;
    in_next_pc[u*32 +: 32] = npc;
    in_rd[u*5 +: 5] = rd;
    in_rd_value[u*32 +: 32] = val;
    in_writeback[u] = wb;
    in_exception[u] = exc;
    in_cause[u*5 +: 5] = cause;
    in_tval[u*32 +: 32] = tval;
    in_mode_return[u] = mret;
    in_wait_irq[u] = wfi;
  endtask

  task automatic tick;
    @(posedge clk_core);
    #1;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_core_n = 1'b0;
    repeat (2) @(posedge clk_core);
    #1 rst_core_n = 1'b1;
  endtask

  // Completes a flush handshake from FLUSH_WAIT back to RUN.
  task automatic finish_flush;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_core_n = 1'b0;
    #12;
    tests_run++; if (commit_token !== 2'd0) begin tests_failed++; $display("FAIL reset_token: got %0d want 0", commit_token); end
    tests_run++; if ({rf_wr_en, ctrl_commit, ctrl_flush_begin, ctrl_trap, ctrl_mode_return, ctrl_wait_irq, flush_ack_commit} !== 7'd0) begin tests_failed++; $display("FAIL reset_flags: got nonzero event flags"); end
    tests_run++; if (ctrl_next_pc !== 32'd0 || rf_wr_data !== 32'd0) begin tests_failed++; $display("FAIL reset_data: next_pc %h rf_data %h want 0", ctrl_next_pc, rf_wr_data); end
    do_reset();
  endtask

  task automatic test_single_retire;
    do_reset();
    set_unit(0, 2'd0, 32'h100, 32'h104, 5'd5, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0);
    #1;
    tests_run++; if (ready_o !== 5'b00001) begin tests_failed++; $display("FAIL single_ready: got %b want 00001", ready_o); end
    tick();
    clear_inputs();
    tests_run++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_rf: en %b addr %0d data %h want 1 5 deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data); end
    tests_run++; if (ctrl_commit !== 1'b1 || commit_token !== 2'd1 || ctrl_next_pc !== 32'h104) begin tests_failed++; $display("FAIL single_commit: commit %b token %0d npc %h want 1 1 104", ctrl_commit, commit_token, ctrl_next_pc); end
    tick();
    tests_run++; if (ctrl_commit !== 1'b0 || rf_wr_en !== 1'b0 || ctrl_next_pc !== 32'h104) begin tests_failed++; $display("FAIL single_pulse: commit %b rf_en %b npc %h want 0 0 104", ctrl_commit, rf_wr_en, ctrl_next_pc); end
  endtask

  task automatic test_out_of_order;
    do_reset();
    set_unit(2, 2'd1, 32'h210, 32'h214, 5'd2, 32'h22, 1, 0, 0, 0, 0, 0);
    #1;
    tests_run++; if (ready_o !== 5'b00000) begin tests_failed++; $display("FAIL ooo_hold: got %b want 00000", ready_o); end
    tick();
    tests_run++; if (ctrl_commit !== 1'b0 || commit_token !== 2'd0) begin tests_failed++; $display("FAIL ooo_stall: commit %b token %0d want 0 0", ctrl_commit, commit_token); end
    set_unit(0, 2'd0, 32'h200, 32'h204, 5'd1, 32'h11, 1, 0, 0, 0, 0, 0);
    #1;
    tests_run++; if (ready_o !== 5'b00001) begin tests_failed++; $display("FAIL ooo_ready_alu: got %b want 00001", ready_o); end
    tick();
    valid_i[0] = 1'b0;
    tests_run++; if (ctrl_commit !== 1'b1 || commit_token !== 2'd1 || rf_wr_addr !== 5'd1 || rf_wr_data !== 32'h11) begin tests_failed++; $display("FAIL ooo_first: commit %b token %0d addr %0d data %h want 1 1 1 11", ctrl_commit, commit_token, rf_wr_addr, rf_wr_data); end
    #1;
    tests_run++; if (ready_o !== 5'b00100) begin tests_failed++; $display("FAIL ooo_ready_mem: got %b want 00100", ready_o); end
    tick();
    clear_inputs();
    tests_run++; if (ctrl_commit !== 1'b1 || commit_token !== 2'd2 || rf_wr_addr !== 5'd2 || rf_wr_data !== 32'h22) begin tests_failed++; $display("FAIL ooo_second: commit %b token %0d addr %0d data %h want 1 2 2 22", ctrl_commit, commit_token, rf_wr_addr, rf_wr_data); end
  endtask

  task automatic test_back_to_back_wrap;
    logic [1:0] tok;
    logic [1:0] exp_tok;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tok = 2'(i);
      exp_tok = 2'(i + 1);
      clear_inputs();
      set_unit(0, tok, 32'h400 + 32'(i * 4), 32'h404 + 32'(i * 4), 5'd9, 32'(i), 1, 0, 0, 0, 0, 0);
      tick();
      tests_run++; if (ctrl_commit !== 1'b1 || commit_token !== exp_tok || rf_wr_data !== 32'(i)) begin tests_failed++; $display("FAIL wrap_%0d: commit %b token %0d data %0d want 1 %0d %0d", i, ctrl_commit, commit_token, rf_wr_data, exp_tok, i); end
    end
    clear_inputs();
  endtask

  task automatic test_x0_write;
    do_reset();
    set_unit(1, 2'd0, 32'h500, 32'h504, 5'd0, 32'h55, 1, 0, 0, 0, 0, 0);
    tick();
    clear_inputs();
    tests_run++; if (rf_wr_en !== 1'b0 || ctrl_commit !== 1'b1 || commit_token !== 2'd1) begin tests_failed++; $display("FAIL x0_write: rf_en %b commit %b token %0d want 0 1 1", rf_wr_en, ctrl_commit, commit_token); end
  endtask

  task automatic test_exception;
    do_reset();
    set_unit(3, 2'd0, 32'h1000, 32'h1004, 5'd7, 32'h77, 1, 1, 5'd0, 32'h1002, 0, 0);
    tick();
    clear_inputs();
    tests_run++; if (ctrl_trap !== 1'b1 || ctrl_flush_begin !== 1'b1 || ctrl_commit !== 1'b0 || rf_wr_en !== 1'b0) begin tests_failed++; $display("FAIL exc_flags: trap %b flush %b commit %b rf_en %b want 1 1 0 0", ctrl_trap, ctrl_flush_begin, ctrl_commit, rf_wr_en); end
    tests_run++; if (ctrl_next_pc !== 32'h1000 || ctrl_trap_cause !== 5'd0 || ctrl_trap_value !== 32'h1002) begin tests_failed++; $display("FAIL exc_data: npc %h cause %0d tval %h want 1000 0 1002", ctrl_next_pc, ctrl_trap_cause, ctrl_trap_value); end
    tests_run++; if (ready_o !== 5'b11111) begin tests_failed++; $display("FAIL exc_drain: got %b want 11111", ready_o); end
    tick();
    tests_run++; if (ctrl_trap !== 1'b0 || ctrl_flush_begin !== 1'b0 || flush_ack_commit !== 1'b0) begin tests_failed++; $display("FAIL exc_pulse: trap %b flush %b ack %b want 0 0 0", ctrl_trap, ctrl_flush_begin, flush_ack_commit); end
    flush_req = 1'b1;
    tick();
    tests_run++; if (flush_ack_commit !== 1'b1 || commit_token !== 2'd0) begin tests_failed++; $display("FAIL exc_ack_rise: ack %b token %0d want 1 0", flush_ack_commit, commit_token); end
    tick();
    tests_run++; if (flush_ack_commit !== 1'b1) begin tests_failed++; $display("FAIL exc_ack_hold: got %b want 1", flush_ack_commit); end
    flush_req = 1'b0;
    tick();
    tests_run++; if (flush_ack_commit !== 1'b0) begin tests_failed++; $display("FAIL exc_ack_fall: got %b want 0", flush_ack_commit); end
    set_unit(0, 2'd0, 32'h600, 32'h604, 5'd3, 32'h33, 1, 0, 0, 0, 0, 0);
    tick();
    clear_inputs();
    tests_run++; if (ctrl_commit !== 1'b1 || commit_token !== 2'd1) begin tests_failed++; $display("FAIL exc_resume: commit %b token %0d want 1 1", ctrl_commit, commit_token); end
  endtask

  task automatic test_mret_wfi;
    do_reset();
    set_unit(4, 2'd0, 32'h700, 32'h800, 5'd0, 32'h0, 0, 0, 0, 0, 1, 0);
    tick();
    clear_inputs();
    tests_run++; if (ctrl_commit !== 1'b1 || ctrl_mode_return !== 1'b1 || ctrl_flush_begin !== 1'b1) begin tests_failed++; $display("FAIL mret: commit %b mret %b flush %b want 1 1 1", ctrl_commit, ctrl_mode_return, ctrl_flush_begin); end
    finish_flush();
    set_unit(4, 2'd0, 32'h900, 32'h904, 5'd0, 32'h0, 0, 0, 0, 0, 0, 1);
    tick();
    clear_inputs();
    tests_run++; if (ctrl_commit !== 1'b1 || ctrl_wait_irq !== 1'b1 || ctrl_flush_begin !== 1'b1 || ctrl_next_pc !== 32'h904) begin tests_failed++; $display("FAIL wfi: commit %b wfi %b flush %b npc %h want 1 1 1 904", ctrl_commit, ctrl_wait_irq, ctrl_flush_begin, ctrl_next_pc); end
    finish_flush();
    set_unit(4, 2'd0, 32'hA00, 32'hA04, 5'd0, 32'h0, 0, 1, 5'd2, 32'hBAD, 0, 1);
    tick();
    clear_inputs();
    tests_run++; if (ctrl_trap !== 1'b1 || ctrl_wait_irq !== 1'b0 || ctrl_commit !== 1'b0 || ctrl_next_pc !== 32'hA00 || ctrl_trap_cause !== 5'd2) begin tests_failed++; $display("FAIL exc_prio: trap %b wfi %b commit %b npc %h cause %0d want 1 0 0 a00 2", ctrl_trap, ctrl_wait_irq, ctrl_commit, ctrl_next_pc, ctrl_trap_cause); end
    finish_flush();
  endtask

  task automatic test_irq;
    do_reset();
    set_unit(0, 2'd0, 32'h2F0, 32'h300, 5'd4, 32'h44, 1, 0, 0, 0, 0, 0);
    tick();
    clear_inputs();
    ctrl_begin_irq = 1'b1;
    tick();
    ctrl_begin_irq = 1'b0;
    tests_run++; if (ctrl_flush_begin !== 1'b1 || ctrl_commit !== 1'b0 || ctrl_next_pc !== 32'h300) begin tests_failed++; $display("FAIL irq_nocand: flush %b commit %b npc %h want 1 0 300", ctrl_flush_begin, ctrl_commit, ctrl_next_pc); end
    finish_flush();
    set_unit(1, 2'd0, 32'h2000, 32'h2004, 5'd6, 32'h66, 1, 0, 0, 0, 0, 0);
    ctrl_begin_irq = 1'b1;
    #1;
    tests_run++; if (ready_o !== 5'b00000) begin tests_failed++; $display("FAIL irq_ready: got %b want 00000", ready_o); end
    tick();
    ctrl_begin_irq = 1'b0;
    tests_run++; if (ctrl_commit !== 1'b0 || ctrl_flush_begin !== 1'b1 || ctrl_next_pc !== 32'h2000 || rf_wr_en !== 1'b0 || commit_token !== 2'd0) begin tests_failed++; $display("FAIL irq_cand: commit %b flush %b npc %h rf_en %b token %0d want 0 1 2000 0 0", ctrl_commit, ctrl_flush_begin, ctrl_next_pc, rf_wr_en, commit_token); end
    tick();
    clear_inputs();
    tests_run++; if (ctrl_commit !== 1'b0 || rf_wr_en !== 1'b0 || ready_o !== 5'b11111) begin tests_failed++; $display("FAIL irq_flushwait: commit %b rf_en %b ready %b want 0 0 11111", ctrl_commit, rf_wr_en, ready_o); end
    finish_flush();
  endtask

  task automatic test_flush_with_retire;
    do_reset();
    set_unit(0, 2'd0, 32'hB00, 32'hB04, 5'd8, 32'h88, 1, 0, 0, 0, 0, 0);
    flush_req = 1'b1;
    tick();
    valid_i = '0;
    tests_run++; if (ctrl_commit !== 1'b1 || rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd8 || ready_o !== 5'b11111) begin tests_failed++; $display("FAIL flush_retire: commit %b rf_en %b addr %0d ready %b want 1 1 8 11111", ctrl_commit, rf_wr_en, rf_wr_addr, ready_o); end
    tick();
    tests_run++; if (flush_ack_commit !== 1'b1 || commit_token !== 2'd0) begin tests_failed++; $display("FAIL flush_retire_ack: ack %b token %0d want 1 0", flush_ack_commit, commit_token); end
    #3 rst_core_n = 1'b0;
    #1;
    tests_run++; if (flush_ack_commit !== 1'b0) begin tests_failed++; $display("FAIL async_reset_ack: got %b want 0", flush_ack_commit); end
    clear_inputs();
    @(posedge clk_core);
    #1 rst_core_n = 1'b1;
    set_unit(0, 2'd0, 32'hC00, 32'hC04, 5'd10, 32'hAA, 1, 0, 0, 0, 0, 0);
    tick();
    clear_inputs();
    tests_run++; if (ctrl_commit !== 1'b1 || commit_token !== 2'd1) begin tests_failed++; $display("FAIL async_reset_run: commit %b token %0d want 1 1", ctrl_commit, commit_token); end
  endtask

  initial begin
    test_reset();
    test_single_retire();
    test_out_of_order();
    test_back_to_back_wrap();
    test_x0_write();
    test_exception();
    test_mret_wfi();
    test_irq();
    test_flush_with_retire();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
